hazard_ctrl: RTL and testbench

- Hazard and scheduling controller for the 5-stage pipelined MIPS datapath.
- Generates the fetch/decode stalls, the execute flush and every forwarding select the datapath consumes.
- Sequences the multiplier: a multiply holds the HI/LO path busy for MULT_LAT cycles, and dependent mfhi/mflo instructions or a back-to-back mult are held in decode.
- Keeps stall and flush performance counters for debug readout.

---
 rtl/mips_pkg.sv | 29 ++
 rtl/fwd_sel.sv | 19 +
 rtl/hazard_ctrl.sv | 112 +++++++++++
 tb/tb_hazard_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - MIPS opcode/funct constants and forward-select encodings
package mips_pkg;

  localparam logic [5:0] OP_RTYPE    = 6'h00;
  localparam logic [5:0] OP_LW       = 6'h23;
  localparam logic [5:0] OP_BEQ      = 6'h04;

  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_JR    = 6'h08;
  localparam logic [5:0] FUNCT_ADD   = 6'h20;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  function automatic logic is_mult(input logic [5:0] op, input logic [5:0] funct);
    return (op == OP_RTYPE) && (funct == FUNCT_MULT || funct == FUNCT_MULTU);
  endfunction

  // Anything that touches HI/LO: must wait out a multiply still in flight.
  function automatic logic uses_hilo(input logic [5:0] op, input logic [5:0] funct);
    return is_mult(op, funct) ||
           ((op == OP_RTYPE) && (funct == FUNCT_MFHI || funct == FUNCT_MFLO));
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// rtl/fwd_sel.sv - M/W priority forward-select comparator for one E-stage source
module fwd_sel
  import mips_pkg::*;
(
  input  logic [4:0] src,
  input  logic [4:0] waM,
  input  logic [4:0] waW,
  input  logic       we_regM,
  input  logic       we_regW,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_RF;
    if (we_regW && (waW != 5'd0) && (waW == src)) sel = FWD_WB;
    if (we_regM && (waM != 5'd0) && (waM == src)) sel = FWD_MEM;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush/forwarding control and multiplier sequencing
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int MULT_LAT = 2,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instrD,
  input  logic [31:0]      instrE,
  input  logic [4:0]       rf_wa_rdtE,
  input  logic [4:0]       rf_wa_rdtM,
  input  logic [4:0]       rf_wa_rdtW,
  input  logic             we_regE,
  input  logic             we_regM,
  input  logic             we_regW,
  input  logic             dm2regE,
  input  logic             dm2regM,
  input  logic             sf2regM,
  input  logic             branchD,
  input  logic             jrD,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushE,
  output logic             fordAD,
  output logic             fordBD,
  output logic [1:0]       fordAE,
  output logic [1:0]       fordBE,
  output logic             fordMultM,
  output logic             mult_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [3:0] LAT = 4'(MULT_LAT);

  logic [4:0]       w_rsD, w_rtD, w_rsE, w_rtE;
  logic             w_multE, w_hiloD;
  logic             w_lw_stall, w_br_stall, w_mul_stall, w_stall;
  logic             w_e_rs, w_e_rt, w_m_rs, w_m_rt;
  logic [1:0]       w_fae, w_fbe;
  logic             w_unused;
  logic [3:0]       r_cnt;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  assign w_rsD = instrD[25:21];
  assign w_rtD = instrD[20:16];
  assign w_rsE = instrE[25:21];
  assign w_rtE = instrE[20:16];
  assign w_unused = ^{instrD[15:6], instrE[15:6]};

  assign w_multE = is_mult(instrE[31:26], instrE[5:0]);
  assign w_hiloD = uses_hilo(instrD[31:26], instrD[5:0]);

  fwd_sel u_fwd_a (
    .src(w_rsE), .waM(rf_wa_rdtM), .waW(rf_wa_rdtW),
    .we_regM(we_regM), .we_regW(we_regW), .sel(w_fae)
  );

  fwd_sel u_fwd_b (
    .src(w_rtE), .waM(rf_wa_rdtM), .waW(rf_wa_rdtW),
    .we_regM(we_regM), .we_regW(we_regW), .sel(w_fbe)
  );

  assign w_e_rs = we_regE & (rf_wa_rdtE != 5'd0) & (rf_wa_rdtE == w_rsD);
  assign w_e_rt = we_regE & (rf_wa_rdtE != 5'd0) & (rf_wa_rdtE == w_rtD);
  assign w_m_rs = dm2regM & (rf_wa_rdtM != 5'd0) & (rf_wa_rdtM == w_rsD);
  assign w_m_rt = dm2regM & (rf_wa_rdtM != 5'd0) & (rf_wa_rdtM == w_rtD);

  assign w_lw_stall  = dm2regE & (rf_wa_rdtE != 5'd0) &
                       ((rf_wa_rdtE == w_rsD) | (rf_wa_rdtE == w_rtD));
  // jr reads only rs, so rt hazards matter for beq alone.
  assign w_br_stall  = (branchD | jrD) &
                       (w_e_rs | w_m_rs | (branchD & (w_e_rt | w_m_rt)));
  assign w_mul_stall = w_hiloD & (w_multE | (r_cnt != 4'd0));
  assign w_stall     = w_lw_stall | w_br_stall | w_mul_stall;

  assign StallF    = rst & w_stall;
  assign StallD    = rst & w_stall;
  assign FlushE    = rst & w_stall;
  assign fordAE    = rst ? w_fae : FWD_RF;
  assign fordBE    = rst ? w_fbe : FWD_RF;
  assign fordAD    = rst & we_regM & (rf_wa_rdtM != 5'd0) & (rf_wa_rdtM == w_rsD);
  assign fordBD    = rst & we_regM & (rf_wa_rdtM != 5'd0) & (rf_wa_rdtM == w_rtD);
  assign fordMultM = rst & sf2regM;
  assign mult_busy = rst & ((r_cnt != 4'd0) | w_multE);
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  // Back-to-back mults are held in D, so a reload never races a decrement.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= 4'd0;
    end else if (w_multE) begin
      r_cnt <= LAT;
    end else if (r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (StallD && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (FlushE && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instrD, instrE;
  logic [4:0]  waE, waM, waW;
  logic        weE, weM, weW, ldE, ldM, sfM, brD, jrD;

  logic        StallF, StallD, FlushE, fordAD, fordBD, fordMultM, mult_busy;
  logic [1:0]  fordAE, fordBE;
  logic [31:0] stall_cnt, flush_cnt;

  logic        s_stf, s_std, s_fle, s_fad, s_fbd, s_fm, s_busy;
  logic [1:0]  s_fae, s_fbe;
  logic [2:0]  s_stall_cnt, s_flush_cnt;

  typedef struct packed {
    logic       stall;
    logic [1:0] fae;
    logic [1:0] fbe;
    logic       fad;
    logic       fbd;
    logic       fm;
    logic       busy;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_stall  = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MULT_LAT(2), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .instrD(instrD), .instrE(instrE),
    .rf_wa_rdtE(waE), .rf_wa_rdtM(waM), .rf_wa_rdtW(waW),
    .we_regE(weE), .we_regM(weM), .we_regW(weW),
    .dm2regE(ldE), .dm2regM(ldM), .sf2regM(sfM), .branchD(brD), .jrD(jrD),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
    .fordAD(fordAD), .fordBD(fordBD), .fordAE(fordAE), .fordBE(fordBE),
    .fordMultM(fordMultM), .mult_busy(mult_busy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.MULT_LAT(2), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .instrD(instrD), .instrE(instrE),
    .rf_wa_rdtE(waE), .rf_wa_rdtM(waM), .rf_wa_rdtW(waW),
    .we_regE(weE), .we_regM(weM), .we_regW(weW),
    .dm2regE(ldE), .dm2regM(ldM), .sf2regM(sfM), .branchD(brD), .jrD(jrD),
    .StallF(s_stf), .StallD(s_std), .FlushE(s_fle),
    .fordAD(s_fad), .fordBD(s_fbd), .fordAE(s_fae), .fordBE(s_fbe),
    .fordMultM(s_fm), .mult_busy(s_busy),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt);
    return {op, rs, rt, 16'd0};
  endfunction

  function automatic exp_t mk(input logic st, input logic [1:0] fae, fbe,
                              input logic fad, fbd, fm, busy);
    exp_t e;
    e = '{stall: st, fae: fae, fbe: fbe, fad: fad, fbd: fbd, fm: fm, busy: busy};
    return e;
  endfunction

  task automatic idle();
    instrD = 32'd0; instrE = 32'd0;
    waE = 5'd0; waM = 5'd0; waW = 5'd0;
    weE = 1'b0; weM = 1'b0; weW = 1'b0;
    ldE = 1'b0; ldM = 1'b0; sfM = 1'b0; brD = 1'b0; jrD = 1'b0;
  endtask

  // Inputs are already driven; push the expectation, compare at negedge, advance.
  task automatic step(input string tag, input exp_t e);
    exp_t x;
    int   sat;
    q.push_back(e);
    @(negedge clk);
    x = q.pop_front();
    chk({tag, ".StallF"}, StallF, x.stall);
    chk({tag, ".StallD"}, StallD, x.stall);
    chk({tag, ".FlushE"}, FlushE, x.stall);
    chk({tag, ".fordAE"}, fordAE, x.fae);
    chk({tag, ".fordBE"}, fordBE, x.fbe);
    chk({tag, ".fordAD"}, fordAD, x.fad);
    chk({tag, ".fordBD"}, fordBD, x.fbd);
    chk({tag, ".fordMultM"}, fordMultM, x.fm);
    chk({tag, ".mult_busy"}, mult_busy, x.busy);
    chk({tag, ".stall_cnt"}, stall_cnt, n_stall);
    chk({tag, ".flush_cnt"}, flush_cnt, n_stall);
    sat = (n_stall > 7) ? 7 : n_stall;
    chk({tag, ".sat_stall_cnt"}, {29'd0, s_stall_cnt}, sat);
    chk({tag, ".sat_flush_cnt"}, {29'd0, s_flush_cnt}, sat);
    n_stall += int'(x.stall);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    instrE = rtype(5'd3, 5'd3, 5'd4, FUNCT_ADD);
    waM = 5'd3; weM = 1'b1; sfM = 1'b1;
    instrD = rtype(5'd3, 5'd3, 5'd0, FUNCT_MFHI);
    waE = 5'd3; weE = 1'b1; ldE = 1'b1; brD = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.StallD", StallD, 1'b0);
    chk("rst.fordAE", fordAE, 2'b00);
    chk("rst.fordAD", fordAD, 1'b0);
    chk("rst.fordMultM", fordMultM, 1'b0);
    chk("rst.mult_busy", mult_busy, 1'b0);
    chk("rst.stall_cnt", stall_cnt, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle();

    // add $3,$1,$2 ; add $4,$3,$3
    instrE = rtype(5'd3, 5'd3, 5'd4, FUNCT_ADD); waM = 5'd3; weM = 1'b1;
    step("fwd_mem", mk(0, 2'b10, 2'b10, 0, 0, 0, 0));
    idle();
    instrE = rtype(5'd3, 5'd3, 5'd5, FUNCT_ADD); waW = 5'd3; weW = 1'b1; waM = 5'd4; weM = 1'b1;
    step("fwd_wb", mk(0, 2'b01, 2'b01, 0, 0, 0, 0));
    idle();
    instrE = rtype(5'd3, 5'd9, 5'd5, FUNCT_ADD);
    waM = 5'd3; weM = 1'b1; waW = 5'd9; weW = 1'b1;
    step("fwd_mix", mk(0, 2'b10, 2'b01, 0, 0, 0, 0));
    idle();
    instrE = rtype(5'd3, 5'd3, 5'd5, FUNCT_ADD); waM = 5'd3; weM = 1'b0; waW = 5'd3; weW = 1'b1;
    step("fwd_prio_we", mk(0, 2'b01, 2'b01, 0, 0, 0, 0));

    // lw $5 ; add $6,$5,$1
    idle();
    instrD = rtype(5'd5, 5'd1, 5'd6, FUNCT_ADD); waE = 5'd5; weE = 1'b1; ldE = 1'b1;
    step("lw_stall", mk(1, 2'b00, 2'b00, 0, 0, 0, 0));
    idle();
    instrD = rtype(5'd5, 5'd1, 5'd6, FUNCT_ADD); waM = 5'd5; weM = 1'b1; ldM = 1'b1;
    step("lw_bubble", mk(0, 2'b00, 2'b00, 1, 0, 0, 0));
    idle();
    instrE = rtype(5'd5, 5'd1, 5'd6, FUNCT_ADD); waW = 5'd5; weW = 1'b1;
    step("lw_fwd", mk(0, 2'b01, 2'b00, 0, 0, 0, 0));
    chk("lw.stall_cnt_is_1", stall_cnt, 32'd1);

    // add $7 ; beq $7,$0
    idle();
    instrD = itype(OP_BEQ, 5'd7, 5'd0); brD = 1'b1; waE = 5'd7; weE = 1'b1;
    step("br_alu_stall", mk(1, 2'b00, 2'b00, 0, 0, 0, 0));
    idle();
    instrD = itype(OP_BEQ, 5'd7, 5'd0); brD = 1'b1; waM = 5'd7; weM = 1'b1;
    step("br_alu_fwd", mk(0, 2'b00, 2'b00, 1, 0, 0, 0));
    // lw $7 ; beq $0,$7
    idle();
    instrD = itype(OP_BEQ, 5'd0, 5'd7); brD = 1'b1; waE = 5'd7; weE = 1'b1; ldE = 1'b1;
    step("br_lw_stall1", mk(1, 2'b00, 2'b00, 0, 0, 0, 0));
    idle();
    instrD = itype(OP_BEQ, 5'd0, 5'd7); brD = 1'b1; waM = 5'd7; weM = 1'b1; ldM = 1'b1;
    step("br_lw_stall2", mk(1, 2'b00, 2'b00, 0, 1, 0, 0));
    idle();
    instrD = itype(OP_BEQ, 5'd0, 5'd7); brD = 1'b1; waW = 5'd7; weW = 1'b1;
    step("br_lw_go", mk(0, 2'b00, 2'b00, 0, 0, 0, 0));
    // jr $9 with a matching rt field must not stall
    idle();
    instrD = rtype(5'd9, 5'd7, 5'd0, FUNCT_JR); jrD = 1'b1; waE = 5'd7; weE = 1'b1;
    step("jr_rt_ignored", mk(0, 2'b00, 2'b00, 0, 0, 0, 0));
    idle();
    instrD = rtype(5'd9, 5'd7, 5'd0, FUNCT_JR); jrD = 1'b1; waE = 5'd9; weE = 1'b1;
    step("jr_rs_stall", mk(1, 2'b00, 2'b00, 0, 0, 0, 0));

    // mult $1,$2 ; mfhi $8
    idle();
    instrD = rtype(5'd0, 5'd0, 5'd8, FUNCT_MFHI); instrE = rtype(5'd1, 5'd2, 5'd0, FUNCT_MULT);
    step("mul_E", mk(1, 2'b00, 2'b00, 0, 0, 0, 1));
    for (int i = 0; i < 2; i++) begin
      idle();
      instrD = rtype(5'd0, 5'd0, 5'd8, FUNCT_MFHI);
      step("mul_cnt", mk(1, 2'b00, 2'b00, 0, 0, 0, 1));
    end
    idle();
    instrD = rtype(5'd0, 5'd0, 5'd8, FUNCT_MFHI);
    step("mul_done", mk(0, 2'b00, 2'b00, 0, 0, 0, 0));
    idle();
    instrE = rtype(5'd0, 5'd0, 5'd8, FUNCT_MFHI);
    step("mfhi_E", mk(0, 2'b00, 2'b00, 0, 0, 0, 0));
    idle();
    sfM = 1'b1; waM = 5'd8; weM = 1'b1;
    step("mfhi_M", mk(0, 2'b00, 2'b00, 0, 0, 1, 0));

    // back-to-back mult/multu
    idle();
    instrD = rtype(5'd3, 5'd4, 5'd0, FUNCT_MULTU); instrE = rtype(5'd1, 5'd2, 5'd0, FUNCT_MULT);
    step("b2b_E", mk(1, 2'b00, 2'b00, 0, 0, 0, 1));
    for (int i = 0; i < 2; i++) begin
      idle();
      instrD = rtype(5'd3, 5'd4, 5'd0, FUNCT_MULTU);
      step("b2b_cnt", mk(1, 2'b00, 2'b00, 0, 0, 0, 1));
    end
    idle();
    instrD = rtype(5'd3, 5'd4, 5'd0, FUNCT_MULTU);
    step("b2b_go", mk(0, 2'b00, 2'b00, 0, 0, 0, 0));

    // $0 destination: never forwarded, never stalls
    idle();
    instrD = rtype(5'd0, 5'd0, 5'd5, FUNCT_ADD); waE = 5'd0; weE = 1'b1; ldE = 1'b1;
    instrE = rtype(5'd0, 5'd0, 5'd6, FUNCT_ADD); waM = 5'd0; weM = 1'b1; waW = 5'd0; weW = 1'b1;
    step("zero_alu", mk(0, 2'b00, 2'b00, 0, 0, 0, 0));
    idle();
    instrD = itype(OP_BEQ, 5'd0, 5'd0); brD = 1'b1; waE = 5'd0; weE = 1'b1;
    waM = 5'd0; weM = 1'b1; ldM = 1'b1;
    step("zero_br", mk(0, 2'b00, 2'b00, 0, 0, 0, 0));

    // reset while a multiply is pending (cnt = 1)
    idle();
    instrE = rtype(5'd1, 5'd2, 5'd0, FUNCT_MULT);
    step("rm_E", mk(0, 2'b00, 2'b00, 0, 0, 0, 1));
    idle();
    step("rm_cnt2", mk(0, 2'b00, 2'b00, 0, 0, 0, 1));
    instrD = rtype(5'd0, 5'd0, 5'd8, FUNCT_MFLO);
    rst = 1'b0;
    #1;
    chk("rm_in_rst.mult_busy", mult_busy, 1'b0);
    chk("rm_in_rst.StallD", StallD, 1'b0);
    chk("rm_in_rst.stall_cnt", stall_cnt, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    n_stall = 0;
    step("rm_release", mk(0, 2'b00, 2'b00, 0, 0, 0, 0));

    // saturation on the narrow-counter instance
    for (int i = 0; i < 10; i++) begin
      idle();
      instrD = rtype(5'd5, 5'd1, 5'd6, FUNCT_ADD); waE = 5'd5; weE = 1'b1; ldE = 1'b1;
      step("sat_lw", mk(1, 2'b00, 2'b00, 0, 0, 0, 0));
    end
    idle();
    step("sat_end", mk(0, 2'b00, 2'b00, 0, 0, 0, 0));
    chk("sat.final", {29'd0, s_stall_cnt}, 32'd7);
    chk("sat.main_final", stall_cnt, 32'd10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
